// File: rtl/fir_ctrl.sv
// fir_ctrl: sequential FIR filter that time-shares one external ALU for all tap multiplies.
module fir_ctrl #(
    parameter int NTAPS   = 8,
    parameter int ALU_LAT = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [31:0] out_data,
    output logic        out_valid,
    input  logic        out_ready,
    input  logic        coef_we,
    input  logic [5:0]  coef_addr,
    input  logic [15:0] coef_data,
    output logic        coef_err,
    output logic [15:0] alu_a,
    output logic [15:0] alu_b,
    output logic [1:0]  alu_op,
    input  logic [31:0] alu_result,
    output logic        busy
);
    localparam int IW = $clog2(NTAPS);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, OUT} state_t;

    state_t               state_q, state_d;
    logic [15:0]          tap_q  [NTAPS];
    logic [15:0]          coef_q [NTAPS];
    logic [IW-1:0]        idx_q;
    logic [31:0]          acc_q, acc_d;
    logic [ALU_LAT-1:0]   vld_q, vld_d;
    logic                 coef_err_q;
    logic                 accept, issue, last, coef_ok, drain_done;

    assign accept     = in_valid && in_ready;
    assign issue      = state_q == RUN;
    assign last       = issue && (idx_q == IW'(NTAPS - 1));
    assign coef_ok    = coef_we && (state_q == IDLE) && (32'(coef_addr) < NTAPS);
    // Bit 0 is the oldest stage; it is accumulated on the same edge DRAIN leaves.
    assign drain_done = (vld_q >> 1) == '0;
    assign coef_err   = coef_err_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = accept     ? RUN   : IDLE;
            RUN:     state_d = last       ? DRAIN : RUN;
            DRAIN:   state_d = drain_done ? OUT   : DRAIN;
            default: state_d = out_ready  ? IDLE  : OUT;
        endcase
    end

    always_comb begin
        in_ready  = rst && (state_q == IDLE);
        busy      = state_q != IDLE;
        out_valid = state_q == OUT;
        out_data  = out_valid ? acc_q : '0;
        alu_a     = issue ? tap_q[idx_q]  : '0;
        alu_b     = issue ? coef_q[idx_q] : '0;
        alu_op    = issue ? 2'b01 : 2'b00;
    end

    always_comb begin
        vld_d = (vld_q >> 1) | (ALU_LAT'(issue) << (ALU_LAT - 1));
        acc_d = accept ? '0 : vld_q[0] ? acc_q + alu_result : acc_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < NTAPS; k++) begin
                tap_q[k]  <= '0;
                coef_q[k] <= '0;
            end
            idx_q      <= '0;
            acc_q      <= '0;
            vld_q      <= '0;
            coef_err_q <= 1'b0;
        end else begin
            if (accept) begin
                tap_q[0] <= in_data;
                for (int k = 1; k < NTAPS; k++) tap_q[k] <= tap_q[k-1];
            end
            if (coef_ok) coef_q[coef_addr[IW-1:0]] <= coef_data;
            idx_q      <= (accept || last) ? '0 : issue ? idx_q + 1'b1 : idx_q;
            acc_q      <= acc_d;
            vld_q      <= vld_d;
            coef_err_q <= coef_we && !coef_ok;
        end
    end
endmodule

// File: tb/tb_fir_ctrl.sv
// tb_fir_ctrl: randomized bench for fir_ctrl against a dot-product reference model.
module tb_fir_ctrl;
    localparam int NT  = 8;
    localparam int LAT = 1;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] in_data, coef_data, alu_a, alu_b;
    logic        in_valid, in_ready, out_valid, out_ready, coef_we, coef_err, busy;
    logic [31:0] out_data, alu_result;
    logic [5:0]  coef_addr;
    logic [1:0]  alu_op;

    int n_chk = 0, n_fail = 0;
    logic signed [15:0] tap_m  [NT];
    logic signed [15:0] coef_m [NT];

    fir_ctrl #(.NTAPS(NT), .ALU_LAT(LAT)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data), .coef_err(coef_err),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_result(alu_result), .busy(busy)
    );

    always #5 clk = ~clk;

    // Single-cycle signed ALU
    always @(posedge clk)
        alu_result <= (alu_op == 2'b01) ? 32'(int'($signed(alu_a)) * int'($signed(alu_b)))
                                        : 32'(int'($signed(alu_a)) + int'($signed(alu_b)));

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic clear_model();
        for (int k = 0; k < NT; k++) begin
            tap_m[k]  = '0;
            coef_m[k] = '0;
        end
    endtask

    function automatic logic [31:0] model_out();
        longint acc = 0;
        for (int k = 0; k < NT; k++) acc += longint'(tap_m[k]) * longint'(coef_m[k]);
        return acc[31:0];
    endfunction

    task automatic wr_coef(input logic [5:0] a, input logic [15:0] d);
        @(negedge clk);
        coef_we = 1'b1; coef_addr = a; coef_data = d;
        @(posedge clk); #1;
        coef_we = 1'b0;
        check("coef_err", coef_err, 32'(a >= NT));
        if (a < NT) coef_m[a] = d;
        else begin
            @(posedge clk); #1;
            check("coef_err_pulse", coef_err, 0);
        end
    endtask

    task automatic send(input logic [15:0] s, input int bp, input bit wr_run,
                        input bit sw, input logic [5:0] sa, input logic [15:0] sd,
                        output logic [31:0] res);
        logic [31:0] exp;
        int n, ops;
        bit bad;
        if (sw && sa < NT) coef_m[sa] = sd;
        for (int k = NT - 1; k > 0; k--) tap_m[k] = tap_m[k-1];
        tap_m[0] = s;
        exp = model_out();
        @(negedge clk);
        check("in_ready_idle", in_ready, 1);
        in_valid = 1'b1; in_data = s;
        coef_we = sw; coef_addr = sa; coef_data = sd;
        @(posedge clk); #1;
        in_valid = 1'b0;
        if (sw) begin
            coef_we = 1'b0;
            check("coef_err_same_edge", coef_err, 32'(sa >= NT));
        end
        n = 0; ops = 0; bad = 0;
        while (!out_valid && n < 4 * (NT + LAT)) begin
            bad |= in_ready | !busy;
            if (alu_op == 2'b01) ops++;
            if (wr_run && n == 2) begin
                coef_we = 1'b1; coef_addr = 6'd0; coef_data = 16'h0005;
            end
            @(posedge clk); #1;
            n++;
            if (coef_we) begin
                coef_we = 1'b0;
                check("coef_err_run", coef_err, 1);
            end
        end
        check("latency", n, NT + LAT);
        check("alu_mul_cycles", ops, NT);
        check("in_ready_low", 32'(bad), 0);
        check("out_data", out_data, exp);
        bad = 0;
        repeat (bp) begin
            @(posedge clk); #1;
            bad |= (out_data !== exp) | !out_valid | in_ready;
        end
        check("bp_hold", 32'(bad), 0);
        res = out_data;
        @(negedge clk) out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("out_released", out_valid, 0);
        check("back_idle", {busy, in_ready}, 2'b01);
    endtask

    initial begin
        logic [31:0] got, prev;
        bit bad;
        in_valid = 0; in_data = 0; out_ready = 0;
        coef_we = 0; coef_addr = 0; coef_data = 0;
        clear_model();
        repeat (2) @(posedge clk); #1;
        check("rst_ctrl", {in_ready, busy, out_valid, coef_err, alu_op}, 0);
        check("rst_out_data", out_data, 0);
        check("rst_alu_ops", {alu_a, alu_b}, 0);
        @(negedge clk) rst = 1'b1;
        #1 check("release_ready", {busy, in_ready}, 2'b01);

        for (int k = 0; k < NT; k++) wr_coef(6'(k), 16'(k + 1));
        for (int i = 0; i <= NT; i++) begin
            send(i == 0 ? 16'd1 : 16'd0, 0, 0, 0, 0, 0, got);
            check("impulse", got, i < NT ? 32'(i + 1) : 32'd0);
        end

        for (int k = 0; k < NT; k++) wr_coef(6'(k), 16'h7fff);
        for (int i = 0; i < NT; i++) send(16'h7fff, 0, 0, 0, 0, 0, got);
        check("wrap", got, 32'hFFF80008);

        wr_coef(6'd0, 16'h8000);
        for (int k = 1; k < NT; k++) wr_coef(6'(k), 16'h0000);
        send(16'h8000, 0, 0, 0, 0, 0, got);
        check("sign", got, 32'h40000000);
        prev = got;

        wr_coef(6'd8, 16'h1234);
        send(16'h8000, 5, 1, 0, 0, 0, got);
        check("guard_same_result", got, prev);

        send(16'h0003, 0, 0, 1, 6'd0, 16'h0010, got);
        check("same_edge_coef", got, 32'd48);

        repeat (24) begin
            if ($urandom_range(0, 1) == 1) wr_coef(6'($urandom_range(0, 11)), 16'($urandom));
            send(16'($urandom), $urandom_range(0, 3), 0,
                 $urandom_range(0, 3) == 0, 6'($urandom_range(0, 9)), 16'($urandom), got);
        end

        @(negedge clk);
        in_valid = 1'b1; in_data = 16'h0001;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2 check("alu_op_mid_run", alu_op, 2'b01);
        rst = 1'b0;
        #1 check("rst_async_ctrl", {busy, in_ready, out_valid, coef_err, alu_op}, 0);
        check("rst_async_alu", {alu_a, alu_b}, 0);
        bad = 0;
        repeat (2) begin
            @(posedge clk); #1;
            bad |= out_valid | in_ready;
        end
        @(negedge clk) rst = 1'b1;
        #1 check("rst_release_ready", in_ready, 1);
        repeat (12) begin
            @(posedge clk); #1;
            bad |= out_valid;
        end
        check("no_partial_output", 32'(bad), 0);
        clear_model();
        send(16'd1, 0, 0, 0, 0, 0, got);
        check("cleared_impulse", got, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
